// File: rtl/tm1638_seq.sv
// tm1638_seq: write-only frame sequencer for a TM1638 LED/7-segment board.
// On a start request the display inputs are snapshotted as one 152-bit
// serial stream (data command, address block, display control). The stream
// is then shifted LSB first onto the STB/CLK/DIO pins. Re-sends happen on an
// update request, a queued request, or a periodic refresh timer.
module tm1638_seq #(
  parameter int HALF    = 25,        // system clocks per serial half-bit
  parameter int GAP     = 2,         // half-bits STB stays high between frames
  parameter int REFRESH = 5_000_000  // idle clocks between auto re-sends, 0 = off
) (
  input  logic        clk_50M,
  input  logic        rst,
  input  logic        update,
  input  logic [31:0] digits,
  input  logic [7:0]  dp,
  input  logic [7:0]  blank,
  input  logic [7:0]  leds,
  input  logic [2:0]  bright,
  input  logic        disp_on,
  output logic        busy,
  output logic        done,
  output logic        stb,
  output logic        clk,
  output logic        dio
);

  localparam int NBITS = 152;
  localparam int TW    = $clog2(GAP * HALF + 1);
  localparam int RW    = (REFRESH > 1) ? $clog2(REFRESH) : 1;

  localparam logic [TW-1:0] HALF_M1  = TW'(HALF - 1);
  localparam logic [TW-1:0] GAP_M1   = TW'(GAP * HALF - 1);
  localparam logic [RW-1:0] REF_LAST = RW'((REFRESH > 0) ? REFRESH - 1 : 0);

  // Last bit index of each frame, and the index one past the whole stream.
  localparam logic [7:0] F0_END = 8'd7;
  localparam logic [7:0] F1_END = 8'd143;
  localparam logic [7:0] F2_END = 8'd151;
  localparam logic [7:0] ALL_DONE = 8'd152;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STB_LO,
    S_BIT_LO,
    S_BIT_HI,
    S_STB_HI,
    S_FIN
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [7:0]       idx_q, idx_d;
  logic [NBITS-1:0] stream_q, stream_d;
  logic             pend_q;
  logic [RW-1:0]    ref_q;
  logic             stb_q, stb_d;
  logic             clk_q, clk_d;
  logic             dio_q, dio_d;
  logic             start;
  logic             ref_hit;
  logic             tmr_zero;
  logic             frame_end;

  // Segment pattern for one hex digit, bit 0 = segment a.
  function automatic logic [6:0] hex7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign ref_hit   = (REFRESH != 0) && (ref_q == REF_LAST);
  assign tmr_zero  = (tmr_q == '0);
  assign frame_end = (idx_q == F0_END) || (idx_q == F1_END) || (idx_q == F2_END);

  // Encode the live inputs into the serial stream; bit 0 is sent first.
  always_comb begin
    stream_d = '0;
    stream_d[7:0]  = 8'h40;
    stream_d[15:8] = 8'hC0;
    for (int i = 0; i < 8; i++) begin
      stream_d[16 + 16*i +: 8] = blank[i] ? 8'h00 : {dp[i], hex7(digits[4*i +: 4])};
      stream_d[24 + 16*i +: 8] = {7'b0, leds[i]};
    end
    stream_d[151:144] = {4'b1000, disp_on, bright};
  end

  // Next state, half-bit timer and bit index.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    idx_d   = idx_q;
    start   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (update || pend_q || ref_hit) begin
          start   = 1'b1;
          state_d = S_STB_LO;
          tmr_d   = HALF_M1;
          idx_d   = '0;
        end
      end
      S_STB_LO: begin
        if (tmr_zero) begin
          state_d = S_BIT_LO;
          tmr_d   = HALF_M1;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_BIT_LO: begin
        if (tmr_zero) begin
          state_d = S_BIT_HI;
          tmr_d   = HALF_M1;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_BIT_HI: begin
        if (tmr_zero) begin
          idx_d = idx_q + 8'd1;
          if (frame_end) begin
            state_d = S_STB_HI;
            tmr_d   = GAP_M1;
          end else begin
            state_d = S_BIT_LO;
            tmr_d   = HALF_M1;
          end
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_STB_HI: begin
        if (tmr_zero) begin
          if (idx_q == ALL_DONE) begin
            state_d = S_FIN;
          end else begin
            state_d = S_STB_LO;
            tmr_d   = HALF_M1;
          end
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pin levels follow the state being entered, so the pins are registered
  // and change together with the state. DIO is loaded on entry to BIT_LO and
  // held through BIT_HI; outside a frame it idles high.
  always_comb begin
    stb_d = !(state_d inside {S_STB_LO, S_BIT_LO, S_BIT_HI});
    clk_d = (state_d != S_BIT_LO);
    case (state_d)
      S_BIT_LO: dio_d = stream_q[idx_d];
      S_BIT_HI: dio_d = dio_q;
      default:  dio_d = 1'b1;
    endcase
  end

  // Sequencer state, snapshot and pin registers.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tmr_q    <= '0;
      idx_q    <= '0;
      stream_q <= '0;
      stb_q    <= 1'b1;
      clk_q    <= 1'b1;
      dio_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      idx_q   <= idx_d;
      stb_q   <= stb_d;
      clk_q   <= clk_d;
      dio_q   <= dio_d;
      if (start) stream_q <= stream_d;
    end
  end

  // One-deep request queue: an update while busy is served after done.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      pend_q <= 1'b0;
    end else if (state_q != S_IDLE && update) begin
      pend_q <= 1'b1;
    end else if (start) begin
      pend_q <= 1'b0;
    end
  end

  // Refresh timer counts idle cycles only and restarts with every sequence.
  always_ff @(posedge clk_50M) begin
    if (rst) begin
      ref_q <= '0;
    end else if (state_q == S_IDLE) begin
      ref_q <= start ? '0 : ref_q + RW'(1);
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_FIN);
  assign stb  = stb_q;
  assign clk  = clk_q;
  assign dio  = dio_q;

endmodule

// File: tb/tb_tm1638_seq.sv
// tb_tm1638_seq: directed + randomized bench for tm1638_seq. A pin monitor
// decodes bits on rising board CLK while STB is low; a byte-level model of
// the TM1638 write sequence supplies expected frames.
module tb_tm1638_seq;

  logic clk_50M = 1'b0;
  always #5 clk_50M = ~clk_50M;

  logic        rst, update, rst2, upd2;
  logic [31:0] digits;
  logic [7:0]  dp, blank, leds;
  logic [2:0]  bright;
  logic        disp_on;
  logic        busy, done, stb, clk, dio;
  logic        busy2, done2, stb2, clk2, dio2;

  tm1638_seq #(.HALF(2), .GAP(2), .REFRESH(0)) dut (
    .clk_50M(clk_50M), .rst(rst), .update(update), .digits(digits), .dp(dp),
    .blank(blank), .leds(leds), .bright(bright), .disp_on(disp_on),
    .busy(busy), .done(done), .stb(stb), .clk(clk), .dio(dio)
  );

  tm1638_seq #(.HALF(2), .GAP(2), .REFRESH(1000)) dutr (
    .clk_50M(clk_50M), .rst(rst2), .update(upd2), .digits(digits), .dp(dp),
    .blank(blank), .leds(leds), .bright(bright), .disp_on(disp_on),
    .busy(busy2), .done(done2), .stb(stb2), .clk(clk2), .dio(dio2)
  );

  int checks = 0;
  int failures = 0;

  // Monitor state for the REFRESH=0 instance
  logic bq[$];
  int   flen[$];
  int   fbits, busy_cyc, done_cnt, start_cnt, stb_falls;
  logic stb_p = 1'b1, clk_p = 1'b1, busy_p = 1'b0;

  logic [7:0] hex_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                              8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  logic [7:0] exp_b [19];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected byte sequence for the current inputs: F0, F1 (cmd + 16), F2.
  task automatic model();
    exp_b[0] = 8'h40;
    exp_b[1] = 8'hC0;
    for (int i = 0; i < 8; i++) begin
      exp_b[2 + 2*i] = blank[i] ? 8'h00 : (hex_tab[digits[4*i +: 4]] | (dp[i] ? 8'h80 : 8'h00));
      exp_b[3 + 2*i] = leds[i] ? 8'h01 : 8'h00;
    end
    exp_b[18] = 8'h80 | (disp_on ? 8'h08 : 8'h00) | {5'b0, bright};
  endtask

  function automatic logic [7:0] got_byte(input int k);
    logic [7:0] b;
    b = '0;
    for (int j = 0; j < 8; j++)
      if (8*k + j < bq.size()) b[j] = bq[8*k + j];
    return b;
  endfunction

  task automatic clr_mon();
    bq.delete();
    flen.delete();
    fbits = 0; busy_cyc = 0; done_cnt = 0; start_cnt = 0; stb_falls = 0;
  endtask

  task automatic check_frames(input string tag);
    chk({tag, "_nbits"}, bq.size(), 152);
    chk({tag, "_nfrm"}, flen.size(), 3);
    for (int f = 0; f < 3; f++)
      chk($sformatf("%s_flen%0d", tag, f), (f < flen.size()) ? flen[f] : -1, (f == 1) ? 136 : 8);
    for (int k = 0; k < 19; k++)
      chk($sformatf("%s_byte%0d", tag, k), got_byte(k), exp_b[k]);
  endtask

  task automatic pulse_update();
    @(posedge clk_50M); #1 update = 1'b1;
    @(posedge clk_50M); #1 update = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (n < 3000 && done !== 1'b1) begin @(negedge clk_50M); n++; end
    chk({tag, "_tmo"}, n < 3000, 1);
  endtask

  task automatic wait_done2(input string tag);
    int n = 0;
    while (n < 3000 && done2 !== 1'b1) begin @(negedge clk_50M); n++; end
    chk({tag, "_tmo"}, n < 3000, 1);
  endtask

  // Idle cycles on the refresh instance before it turns busy again.
  task automatic count_idle2(output int k);
    bit found = 0;
    k = 0;
    for (int n = 0; n < 1200 && !found; n++) begin
      @(posedge clk_50M); #1;
      if (busy2) found = 1; else k++;
    end
  endtask

  task automatic run_one(input string tag);
    @(posedge clk_50M); #1;
    clr_mon();
    model();
    chk({tag, "_idle"}, busy, 0);
    pulse_update();
    @(negedge clk_50M);
    chk({tag, "_lat"}, {stb, busy}, 2'b01);
    wait_done(tag);
    @(posedge clk_50M); #1;
    check_frames(tag);
    chk({tag, "_busycyc"}, busy_cyc, 627);
    chk({tag, "_stbwin"}, stb_falls, 3);
    @(negedge clk_50M);
    chk({tag, "_done1"}, done_cnt, 1);
    chk({tag, "_busy0"}, busy, 0);
  endtask

  initial begin
    int k;
    int n;
    rst = 1'b1; rst2 = 1'b1; update = 1'b0; upd2 = 1'b0;
    digits = '0; dp = '0; blank = '0; leds = '0; bright = '0; disp_on = 1'b0;
    clr_mon();

    // Pin monitor for the REFRESH=0 instance
    fork
      forever begin
        @(negedge clk_50M);
        if (busy === 1'b1) busy_cyc++;
        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1 && busy_p !== 1'b1) start_cnt++;
        if (stb === 1'b0 && stb_p === 1'b1) begin stb_falls++; fbits = 0; end
        if (stb === 1'b0 && clk === 1'b1 && clk_p === 1'b0) begin bq.push_back(dio); fbits++; end
        if (stb === 1'b1 && stb_p === 1'b0) flen.push_back(fbits);
        stb_p = stb; clk_p = clk; busy_p = busy;
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk_50M);
    @(negedge clk_50M);
    chk("rst_pins", {stb, clk, dio, busy, done}, 5'b11100);
    chk("rst_pins2", {stb2, clk2, dio2, busy2, done2}, 5'b11100);
    @(posedge clk_50M); #1 rst = 1'b0;

    // Plan vector: digits 0..7, leds A5, full brightness
    digits = 32'h76543210; dp = 8'h00; blank = 8'h00; leds = 8'hA5; bright = 3'd7; disp_on = 1'b1;
    run_one("basic");

    // Blanking and decimal point
    digits = 32'hFFFF0008; dp = 8'h01; blank = 8'hF0; leds = 8'($urandom);
    run_one("blank");

    // Randomized inputs
    for (int r = 0; r < 3; r++) begin
      digits = $urandom; dp = 8'($urandom); blank = 8'($urandom); leds = 8'($urandom);
      bright = 3'($urandom); disp_on = 1'($urandom);
      run_one($sformatf("rnd%0d", r));
    end

    // Display control byte 0x83
    digits = $urandom; bright = 3'd3; disp_on = 1'b0;
    run_one("f2");

    // Two updates mid-sequence: one follow-on with the latest inputs
    digits = 32'h01234567; dp = 8'h00; blank = 8'h00; leds = 8'h3C; bright = 3'd5; disp_on = 1'b1;
    @(posedge clk_50M); #1;
    clr_mon();
    model();
    pulse_update();
    repeat (100) @(posedge clk_50M);
    #1 digits = 32'h89ABCDEF;
    pulse_update();
    repeat (100) @(posedge clk_50M);
    #1 digits = $urandom; leds = 8'($urandom); dp = 8'($urandom);
    pulse_update();
    wait_done("pend_a");
    @(posedge clk_50M); #1;
    check_frames("pend_a");
    clr_mon();
    model();
    @(negedge clk_50M);
    chk("pend_gap", busy, 0);
    @(negedge clk_50M);
    chk("pend_start", {stb, busy}, 2'b01);
    wait_done("pend_b");
    @(posedge clk_50M); #1;
    check_frames("pend_b");
    repeat (700) @(posedge clk_50M);
    #1;
    chk("pend_starts", start_cnt, 1);
    chk("pend_dones", done_cnt, 1);

    // Reset in the middle of F1, then a clean restart
    digits = $urandom; leds = 8'($urandom);
    @(posedge clk_50M); #1;
    clr_mon();
    pulse_update();
    n = 0;
    while (n < 2000 && bq.size() < 78) begin @(negedge clk_50M); n++; end
    chk("abort_tmo", n < 2000, 1);
    rst = 1'b1;
    @(negedge clk_50M);
    chk("abort_pins", {stb, clk, dio, busy, done}, 5'b11100);
    @(posedge clk_50M); #1 rst = 1'b0;
    repeat (20) @(posedge clk_50M);
    #1;
    chk("abort_nodone", done_cnt, 0);
    chk("abort_idle", busy, 0);
    run_one("restart");

    // Auto refresh on the REFRESH=1000 instance
    @(posedge clk_50M); #1 rst2 = 1'b0;
    count_idle2(k);
    chk("ref_first", k, 999);
    wait_done2("ref_d1");
    count_idle2(k);
    chk("ref_idle1", k, 1000);
    wait_done2("ref_d2");
    // Update lands on the same cycle as the refresh expiry
    for (int m = 0; m < 1000; m++) begin @(posedge clk_50M); #1; end
    chk("coin_pre", busy2, 0);
    upd2 = 1'b1;
    @(posedge clk_50M); #1 upd2 = 1'b0;
    chk("coin_start", busy2, 1);
    wait_done2("coin_d");
    count_idle2(k);
    chk("coin_single", k, 1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
